// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals for the three-way memory arbiter.
// Latency: none, wires only.
// Backpressure: requesters see wait_o/done; memory side uses a req/ack handshake.
// Modports:
//   slave  - the arbiter: takes req/we/addr/wdata and mem_rdata/mem_ack,
//            drives done/wait_o/rdata/gnt_id and mem_req/mem_we/mem_addr/mem_wdata.
//   master - requesters plus memory model: the reverse directions.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // Requester side; requester i packed at [i*W +: W].
  logic [2:0]          req;
  logic [2:0]          we;
  logic [3*ADDR_W-1:0] addr;
  logic [3*DATA_W-1:0] wdata;
  logic [2:0]          done;
  logic [2:0]          wait_o;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          gnt_id;

  // Memory side.
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_ack;

  modport slave (
    input  req, we, addr, wdata, mem_rdata, mem_ack,
    output done, wait_o, rdata, gnt_id, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, wdata, mem_rdata, mem_ack,
    input  done, wait_o, rdata, gnt_id, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates three requesters (0 data, 1 fetch, 2 dma) onto one memory port.
// Latency: grant one edge after req seen in IDLE; done one cycle after mem_ack; IDLE the cycle after.
// Backpressure: mem_ack may stall BUSY indefinitely; losing requesters hold with wait_o high.
// Ports: clk, rst (async, active-high) plus the mem_arbiter_if.slave bundle `bus`.
// Build option: define ARB_ROUND_ROBIN_EN for rotating priority; otherwise fixed 0 > 1 > 2.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;

  logic                win_vld;
  logic [1:0]          win_id;

  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          gnt_q;
  logic [2:0]          done_vec;

`ifdef ARB_ROUND_ROBIN_EN
  // Pointer holds the last winner; search starts at the next index.
  logic [1:0] rr_ptr;

  function automatic logic [1:0] rr_index(input logic [1:0] ptr, input int k);
    int s;
    s = int'(ptr) + k;
    if (s >= 3) s = s - 3;
    return s[1:0];
  endfunction

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    win_vld = 1'b0;
    win_id  = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      if (bus.req[rr_index(rr_ptr, k)]) begin
        win_vld = 1'b1;
        win_id  = rr_index(rr_ptr, k);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 2'd0;
    end else if (state_q == IDLE && win_vld) begin
      rr_ptr <= win_id;
    end
  end
`else
  always_comb begin
    win_vld = |bus.req;
    win_id  = 2'd0;
    if (bus.req[0])      win_id = 2'd0;
    else if (bus.req[1]) win_id = 2'd1;
    else if (bus.req[2]) win_id = 2'd2;
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_vld)     state_d = BUSY;
      BUSY:    if (bus.mem_ack) state_d = DONE;
      DONE:                     state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Memory request registers: loaded at grant, held through BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      gnt_q       <= 2'd0;
    end else begin
      if (state_q == IDLE && win_vld) begin
        mem_req_q   <= 1'b1;
        // Fetch port is read-only regardless of its we bit.
        mem_we_q    <= bus.we[win_id] & (win_id != 2'd1);
        mem_addr_q  <= bus.addr[int'(win_id)*ADDR_W +: ADDR_W];
        mem_wdata_q <= bus.wdata[int'(win_id)*DATA_W +: DATA_W];
        gnt_q       <= win_id;
      end
      // Ack outside BUSY is a stray strobe and is ignored.
      if (state_q == BUSY && bus.mem_ack) begin
        mem_req_q <= 1'b0;
        rdata_q   <= bus.mem_rdata;
      end
    end
  end

  assign done_vec      = (state_q == DONE) ? (3'b001 << gnt_q) : 3'b000;

  assign bus.done      = done_vec;
  assign bus.wait_o    = bus.req & ~done_vec;
  assign bus.rdata     = rdata_q;
  assign bus.gnt_id    = gnt_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level priority model.
// Inputs driven 1 time unit after the rising edge; outputs sampled there as well.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   last_win = 0;
  logic [DW-1:0] exp_rdata = '0;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference priority rule, stated directly in terms of requester indices.
  function automatic int predict(input logic [2:0] r, input int lst);
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 3; k++) if (r[(lst + k) % 3]) return (lst + k) % 3;
    return lst;
`else
    for (int i = 0; i < 3; i++) if (r[i]) return i;
    return 0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    last_win  = 0;
    exp_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    bus.mem_rdata = '0; bus.mem_ack = 1'b0;
    step(); step();
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.rdata, bus.done, bus.gnt_id} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h rdata=%h done=%b gnt=%0d, all required 0",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.rdata, bus.done, bus.gnt_id);
    end
    checks++;
    if (bus.wait_o !== 3'b000) begin
      failures++;
      $display("FAIL reset_wait: got %b required 000", bus.wait_o);
    end
    rst = 1'b0;
    last_win = 0;
    exp_rdata = '0;
  endtask

  task automatic test_single_fetch();
    // we[1] set on purpose: the fetch port must never write.
    bus.req = 3'b010; bus.we = 3'b010;
    bus.addr = {16'h0000, 16'h0100, 16'h0000};
    #1;
    checks++;
    if (bus.wait_o !== 3'b010) begin
      failures++; $display("FAIL fetch_wait_idle: got %b required 010", bus.wait_o);
    end
    step();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0100 || bus.mem_we !== 1'b0 || bus.gnt_id !== 2'd1) begin
      failures++;
      $display("FAIL fetch_issue: req=%b addr=%h we=%b gnt=%0d required 1/0100/0/1",
               bus.mem_req, bus.mem_addr, bus.mem_we, bus.gnt_id);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hBEEF;
    checks++;
    if (bus.done !== 3'b000) begin
      failures++; $display("FAIL fetch_done_early: got %b required 000", bus.done);
    end
    step();
    checks++;
    if (bus.done !== 3'b010 || bus.rdata !== 16'hBEEF || bus.mem_req !== 1'b0 || bus.wait_o !== 3'b000) begin
      failures++;
      $display("FAIL fetch_done: done=%b rdata=%h mem_req=%b wait=%b required 010/beef/0/000",
               bus.done, bus.rdata, bus.mem_req, bus.wait_o);
    end
    bus.mem_ack = 1'b0; bus.req = 3'b000; bus.we = 3'b000;
    step();
    checks++;
    if (bus.done !== 3'b000 || bus.mem_req !== 1'b0) begin
      failures++; $display("FAIL fetch_idle: done=%b mem_req=%b required 000/0", bus.done, bus.mem_req);
    end
    last_win = 1;
    exp_rdata = 16'hBEEF;
  endtask

  task automatic test_contention();
    int exp_ord[4];
`ifdef ARB_ROUND_ROBIN_EN
    exp_ord = '{1, 2, 0, 1};
`else
    exp_ord = '{0, 0, 0, 0};
`endif
    do_reset();
    bus.req = 3'b111; bus.we = 3'b000;
    bus.addr = {16'h0C02, 16'h0B01, 16'h0A00};
    for (int n = 0; n < 4; n++) begin
      step();
      checks++;
      if (bus.mem_req !== 1'b1 || bus.gnt_id !== 2'(exp_ord[n]) ||
          bus.mem_addr !== bus.addr[exp_ord[n]*AW +: AW]) begin
        failures++;
        $display("FAIL contention_grant%0d: mem_req=%b gnt=%0d addr=%h required 1/%0d",
                 n, bus.mem_req, bus.gnt_id, bus.mem_addr, exp_ord[n]);
      end
      bus.mem_ack = 1'b1; bus.mem_rdata = 16'(n);
      step();
      checks++;
      if (bus.done !== 3'(1 << exp_ord[n]) || bus.wait_o !== (3'b111 & ~3'(1 << exp_ord[n]))) begin
        failures++;
        $display("FAIL contention_done%0d: done=%b wait=%b required done for %0d",
                 n, bus.done, bus.wait_o, exp_ord[n]);
      end
      bus.mem_ack = 1'b0;
      step();
    end
    bus.req = 3'b000;
    last_win = exp_ord[3];
    exp_rdata = 16'd3;
  endtask

  task automatic test_wait_states();
    bus.req = 3'b001; bus.we = 3'b001;
    bus.addr = {16'h0, 16'h0, 16'h2000};
    bus.wdata = {16'h0, 16'h0, 16'h1234};
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h2000 ||
          bus.mem_wdata !== 16'h1234 || bus.wait_o[0] !== 1'b1 || bus.done !== 3'b000) begin
        failures++;
        $display("FAIL wait_hold%0d: req=%b we=%b addr=%h wdata=%h wait0=%b done=%b required 1/1/2000/1234/1/000",
                 i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.wait_o[0], bus.done);
      end
      if (i == 4) begin bus.mem_ack = 1'b1; bus.mem_rdata = 16'h5A5A; end
      step();
    end
    checks++;
    if (bus.done !== 3'b001 || bus.wait_o[0] !== 1'b0 || bus.rdata !== 16'h5A5A) begin
      failures++;
      $display("FAIL wait_done: done=%b wait0=%b rdata=%h required 001/0/5a5a", bus.done, bus.wait_o[0], bus.rdata);
    end
    bus.mem_ack = 1'b0; bus.req = 3'b000; bus.we = 3'b000;
    step();
    last_win = 0;
    exp_rdata = 16'h5A5A;
  endtask

  task automatic test_withdraw();
    int pulses = 0;
    bus.req = 3'b100; bus.we = 3'b100;
    bus.addr = {16'h3000, 16'h0, 16'h0};
    step();
    checks++;
    if (bus.gnt_id !== 2'd2 || bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h3000) begin
      failures++;
      $display("FAIL withdraw_grant: gnt=%0d we=%b addr=%h required 2/1/3000", bus.gnt_id, bus.mem_we, bus.mem_addr);
    end
    bus.req = 3'b000;
    for (int i = 0; i < 6; i++) begin
      bus.mem_ack = (i == 2);
      bus.mem_rdata = 16'h7777;
      step();
      if (bus.done[2] === 1'b1) pulses++;
    end
    bus.mem_ack = 1'b0;
    checks++;
    if (pulses != 1 || bus.rdata !== 16'h7777) begin
      failures++;
      $display("FAIL withdraw_done: pulses=%0d rdata=%h required 1/7777", pulses, bus.rdata);
    end
    last_win = 2;
    exp_rdata = 16'h7777;
  endtask

  task automatic test_stray_ack();
    bus.req = 3'b000; bus.mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.mem_rdata = 16'($urandom);
      step();
      checks++;
      if (bus.mem_req !== 1'b0 || bus.done !== 3'b000 || bus.rdata !== exp_rdata) begin
        failures++;
        $display("FAIL stray_ack%0d: mem_req=%b done=%b rdata=%h required 0/000/%h",
                 i, bus.mem_req, bus.done, bus.rdata, exp_rdata);
      end
    end
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_reset_busy();
    bus.req = 3'b001; bus.we = 3'b001;
    bus.addr = {16'h0, 16'h0, 16'h4444}; bus.wdata = {16'h0, 16'h0, 16'h9999};
    step();
    checks++;
    if (bus.mem_req !== 1'b1) begin
      failures++; $display("FAIL rstbusy_enter: mem_req=%b required 1", bus.mem_req);
    end
    rst = 1'b1;
    bus.req = 3'b000; bus.we = 3'b000;
    #1;
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.rdata, bus.done, bus.gnt_id} !== '0) begin
      failures++;
      $display("FAIL rstbusy_async: req=%b we=%b addr=%h wdata=%h rdata=%h done=%b gnt=%0d required all 0",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.rdata, bus.done, bus.gnt_id);
    end
    step();
    rst = 1'b0;
    last_win = 0;
    exp_rdata = '0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.rdata, bus.done, bus.gnt_id} !== '0) begin
        failures++;
        $display("FAIL rstbusy_stray%0d: req=%b rdata=%h done=%b gnt=%0d required all 0",
                 i, bus.mem_req, bus.rdata, bus.done, bus.gnt_id);
      end
    end
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_random();
    logic [2:0]      r;
    logic [2:0]      we_v;
    logic [3*AW-1:0] addr_v;
    logic [3*DW-1:0] wdata_v;
    logic [DW-1:0]   rd;
    int              w;
    int              d;
    for (int n = 0; n < 80; n++) begin
      r       = 3'($urandom_range(0, 7));
      we_v    = 3'($urandom);
      addr_v  = {16'($urandom), 16'($urandom), 16'($urandom)};
      wdata_v = {16'($urandom), 16'($urandom), 16'($urandom)};
      bus.req = r; bus.we = we_v; bus.addr = addr_v; bus.wdata = wdata_v;
      bus.mem_ack = (r == 3'b000) ? 1'($urandom) : 1'b0;
      #1;
      checks++;
      if (bus.wait_o !== r) begin
        failures++; $display("FAIL rnd_wait_idle%0d: got %b required %b", n, bus.wait_o, r);
      end
      step();
      if (r == 3'b000) begin
        checks++;
        if (bus.mem_req !== 1'b0 || bus.done !== 3'b000) begin
          failures++; $display("FAIL rnd_idle%0d: mem_req=%b done=%b required 0/000", n, bus.mem_req, bus.done);
        end
        bus.mem_ack = 1'b0;
        continue;
      end
      w = predict(r, last_win);
      last_win = w;
      checks++;
      if (bus.mem_req !== 1'b1 || bus.gnt_id !== 2'(w) ||
          bus.mem_we !== (we_v[w] && w != 1) ||
          bus.mem_addr !== addr_v[w*AW +: AW] || bus.mem_wdata !== wdata_v[w*DW +: DW]) begin
        failures++;
        $display("FAIL rnd_grant%0d: req=%b gnt=%0d we=%b addr=%h wdata=%h required gnt %0d of req %b",
                 n, bus.mem_req, bus.gnt_id, bus.mem_we, bus.mem_addr, bus.mem_wdata, w, r);
      end
      bus.req = r & 3'($urandom);
      d = $urandom_range(0, 3);
      for (int i = 0; i < d; i++) begin
        step();
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== addr_v[w*AW +: AW] ||
            bus.mem_wdata !== wdata_v[w*DW +: DW] || bus.done !== 3'b000 || bus.wait_o !== bus.req) begin
          failures++;
          $display("FAIL rnd_hold%0d_%0d: req=%b addr=%h wdata=%h done=%b wait=%b",
                   n, i, bus.mem_req, bus.mem_addr, bus.mem_wdata, bus.done, bus.wait_o);
        end
      end
      rd = 16'($urandom);
      bus.mem_ack = 1'b1; bus.mem_rdata = rd;
      step();
      exp_rdata = rd;
      checks++;
      if (bus.done !== 3'(1 << w) || bus.rdata !== rd || bus.mem_req !== 1'b0) begin
        failures++;
        $display("FAIL rnd_done%0d: done=%b rdata=%h mem_req=%b required %b/%h/0",
                 n, bus.done, bus.rdata, bus.mem_req, 3'(1 << w), rd);
      end
      bus.mem_ack = 1'b0;
      step();
      checks++;
      if (bus.done !== 3'b000 || bus.mem_req !== 1'b0) begin
        failures++; $display("FAIL rnd_back_idle%0d: done=%b mem_req=%b required 000/0", n, bus.done, bus.mem_req);
      end
    end
    bus.req = 3'b000;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_wait_states();
    test_withdraw();
    test_stray_ack();
    test_reset_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, address width of every requester and of the memory port.
REQ-002 Parameter DATA_W, default 16, data width of every requester and of the memory port.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous reset, active-high.
REQ-005 req  input  3  per-requester access request; index 0 data (load/store), 1 fetch, 2 dma.
REQ-006 we  input  3  per-requester write enable; we[1] ignored and treated as 0.
REQ-007 addr  input  3*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W].
REQ-008 wdata  input  3*DATA_W  packed write data, same packing as addr.
REQ-009 done  output  3  one-cycle completion pulse per requester.
REQ-010 wait_o  output  3  combinational req & ~done; drives the control FSM mem_wait.
REQ-011 rdata  output  DATA_W  registered read data of the last completed access.
REQ-012 mem_req  output  1  registered memory request.
REQ-013 mem_we  output  1  registered memory write enable.
REQ-014 mem_addr  output  ADDR_W  registered memory address.
REQ-015 mem_wdata  output  DATA_W  registered memory write data.
REQ-016 mem_rdata  input  DATA_W  memory read data, valid in the mem_ack cycle.
REQ-017 mem_ack  input  1  memory completion strobe for the outstanding request.
REQ-018 gnt_id  output  2  index of the current/last granted requester; 2'd3 never driven.

Function
REQ-019 FSM states IDLE, BUSY, DONE; IDLE->BUSY when any req bit is 1; BUSY->DONE on mem_ack; DONE->IDLE unconditionally.
REQ-020 Arbitration SHALL occur only in IDLE; the winner's we/addr/wdata and index are latched at that edge into mem_we/mem_addr/mem_wdata/gnt_id, and mem_req is set to 1.
REQ-021 mem_req, mem_we, mem_addr, mem_wdata SHALL be held stable throughout BUSY; mem_req clears on the edge leaving BUSY.
REQ-022 On the mem_ack edge, rdata SHALL capture mem_rdata (writes included); done[gnt_id] is 1 for exactly the DONE cycle.
REQ-023 Minimum latency: req sampled in IDLE at cycle 0 -> mem_req 1 in cycle 1 -> mem_ack in cycle 1 -> done in cycle 2 -> IDLE in cycle 3.
REQ-024 Unbounded mem_ack delay SHALL be tolerated; the arbiter remains in BUSY.
REQ-025 A requester deasserting req during BUSY SHALL NOT abort the access; done is still pulsed.
REQ-026 A requester that keeps req high through its done cycle SHALL be treated as a new request in the following IDLE cycle.
REQ-027 mem_ack outside BUSY SHALL be ignored.
REQ-028 Simultaneous requests SHALL be resolved by the priority rule of REQ-032/REQ-033; losers remain pending with wait_o high.

Reset
REQ-029 While rst is high: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, rdata 0, done 0, gnt_id 0, round-robin pointer 0.
REQ-030 Reset asserted in BUSY SHALL abandon the access with no done pulse; a late mem_ack after reset is ignored per REQ-027.
REQ-031 The first arbitration SHALL occur on the first rising edge after rst deasserts.

Configuration
REQ-032 With ARB_ROUND_ROBIN_EN defined: rotating priority starting at the index after the last winner (0->1->2->0); the pointer updates at each grant and is 0 after reset, so index 1 has highest priority first.
REQ-033 Without ARB_ROUND_ROBIN_EN: fixed priority data(0) > fetch(1) > dma(2); no pointer state is synthesized.

Verification
REQ-034 Single fetch: req=3'b010, addr[1]=16'h0100, mem_ack one cycle after mem_req, mem_rdata=16'hBEEF -> mem_addr=16'h0100, mem_we=0, done=3'b010 in cycle 2, rdata=16'hBEEF.
REQ-035 Contention, fixed priority: req=3'b111 held -> grant order 0,0,0... (fetch and dma starve while data holds req); with ARB_ROUND_ROBIN_EN -> order 1,2,0,1.
REQ-036 Wait states: data write addr 16'h2000, wdata 16'h1234, mem_ack after 5 BUSY cycles -> mem_req, mem_we=1, mem_addr, mem_wdata stable all 5 cycles; wait_o[0]=1 until done[0].
REQ-037 Withdraw: dma req dropped after grant -> access completes, done[2] pulses once.
REQ-038 Reset mid-BUSY, then stray mem_ack -> all outputs 0, no done pulse, state IDLE.
